seg_scroll_ctrl: RTL and testbench

Display controller for the 8-digit seven-segment bank. It owns the per-digit pattern state and schedules what each digit shows:
- Clients write hex digits into a shadow buffer through a valid/ready port.
- A commit transfers the shadow buffer atomically to the active buffer.
- The active buffer is shown either static or rotating (scrolling) at a programmable rate.

Drives o_seg0..o_seg7 (active-low) directly to the board pins.

---
 rtl/seg_scroll_ctrl_if.sv | 11 +
 rtl/seg_scroll_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scroll_ctrl_if.sv
// Digit-write port of the seven-segment scroll controller: valid/ready handshake
// carrying a digit index and a 5-bit digit word (enable + hex value).
interface seg_scroll_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_idx;
    logic [4:0] wr_data;

    modport master (output wr_valid, output wr_idx, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_idx, input wr_data, output wr_ready);
endinterface

// File: rtl/seg_scroll_ctrl.sv
// 8-digit seven-segment controller: shadow/active digit buffers, atomic commit, static or scrolling display.
// Optional macro SEG_LZ_BLANK_EN enables leading-zero suppression in the static display.
module seg_scroll_ctrl #(
    parameter int unsigned CLK_NUM = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scroll_ctrl_if.slave  wr,
    input  logic              commit,
    input  logic              mode,
    output logic [7:0]        o_seg0,
    output logic [7:0]        o_seg1,
    output logic [7:0]        o_seg2,
    output logic [7:0]        o_seg3,
    output logic [7:0]        o_seg4,
    output logic [7:0]        o_seg5,
    output logic [7:0]        o_seg6,
    output logic [7:0]        o_seg7,
    output logic              busy
);

    localparam logic [31:0] LastCount = 32'(CLK_NUM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STATIC = 2'd1,
        SCROLL = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [4:0]  shadow_q [8];
    logic [4:0]  shadow_d [8];
    logic [4:0]  active_q [8];
    logic [4:0]  active_d [8];
    logic [2:0]  offset_q,  offset_d;
    logic [31:0] count_q,   count_d;
    logic        pending_q, pending_d;
    logic        copyNow;

    // Segment pattern with a..g in bits 7..1; dp is never lit
    function automatic logic [7:0] pat(input logic [3:0] v);
        logic [7:0] p;
        case (v)
            4'h0: p = 8'hFC;
            4'h1: p = 8'h60;
            4'h2: p = 8'hDA;
            4'h3: p = 8'hF2;
            4'h4: p = 8'h66;
            4'h5: p = 8'hB6;
            4'h6: p = 8'hBE;
            4'h7: p = 8'hE0;
            4'h8: p = 8'hFE;
            4'h9: p = 8'hF6;
            4'hA: p = 8'hEE;
            4'hB: p = 8'h3E;
            4'hC: p = 8'h9C;
            4'hD: p = 8'h7A;
            4'hE: p = 8'h9E;
            default: p = 8'h8E;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            offset_q  <= 3'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 5'd0;
                active_q[i] <= 5'd0;
            end
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // The copy reads the pre-edge shadow, so a write landing on the commit edge is already in it one edge later
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        offset_d  = offset_q;
        count_d   = count_q;
        pending_d = pending_q;
        copyNow   = 1'b0;

        if (wr.wr_valid && !pending_q) begin
            shadow_d[wr.wr_idx] = wr.wr_data;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    copyNow = 1'b1;
                    state_d = mode ? SCROLL : STATIC;
                end
            end
            STATIC: begin
                copyNow = pending_q;
                if (mode) begin
                    state_d = SCROLL;
                    count_d = 32'd0;
                end
            end
            SCROLL: begin
                if (!mode) begin
                    state_d  = STATIC;
                    offset_d = 3'd0;
                    count_d  = 32'd0;
                end else if (count_q == LastCount) begin
                    count_d  = 32'd0;
                    offset_d = offset_q + 3'd1;
                    copyNow  = pending_q;
                end else begin
                    count_d = count_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (copyNow) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (commit && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    assign wr.wr_ready = !pending_q;
    assign busy        = pending_q;

    logic [7:0] segs [8];
    logic [4:0] digit;
`ifdef SEG_LZ_BLANK_EN
    logic       leading;
`endif

    // Output position K shows active digit (K + offset) mod 8; 3-bit addition gives the wrap
    always_comb begin
        digit = 5'd0;
        for (int k = 0; k < 8; k++) begin
            digit   = active_q[3'(k) + offset_q];
            segs[k] = (state_q != IDLE && digit[4]) ? ~pat(digit[3:0]) : 8'hFF;
        end
`ifdef SEG_LZ_BLANK_EN
        leading = 1'b0;
        if (state_q == STATIC) begin
            leading = 1'b1;
            for (int k = 7; k >= 1; k--) begin
                if (leading && active_q[k][4] && active_q[k][3:0] == 4'h0) begin
                    segs[k] = 8'hFF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    assign o_seg0 = segs[0];
    assign o_seg1 = segs[1];
    assign o_seg2 = segs[2];
    assign o_seg3 = segs[3];
    assign o_seg4 = segs[4];
    assign o_seg5 = segs[5];
    assign o_seg6 = segs[6];
    assign o_seg7 = segs[7];

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Bench for seg_scroll_ctrl: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the display rules (honours SEG_LZ_BLANK_EN).
module tb_seg_scroll_ctrl;

    localparam int ClkNum   = 4;
    localparam int PhIdle   = 0;
    localparam int PhStatic = 1;
    localparam int PhScroll = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       commit;
    logic       mode;
    logic [7:0] o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;
    logic       busy;

    seg_scroll_ctrl_if wrIf();

    seg_scroll_ctrl #(.CLK_NUM(ClkNum)) dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wrIf.slave),
        .commit (commit),
        .mode   (mode),
        .o_seg0 (o_seg0),
        .o_seg1 (o_seg1),
        .o_seg2 (o_seg2),
        .o_seg3 (o_seg3),
        .o_seg4 (o_seg4),
        .o_seg5 (o_seg5),
        .o_seg6 (o_seg6),
        .o_seg7 (o_seg7),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [4:0] mShadow [8];
    logic [4:0] mActive [8];
    int         mOffset;
    int         mCount;
    bit         mPending;
    int         mPhase;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        logic [7:0] table16 [16];
        table16 = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        return ~table16[v];
    endfunction

    function automatic logic [63:0] expectedSegs();
        logic [63:0] r;
        logic [4:0]  d;
        bit          lead;
        r = '1;
        if (mPhase == PhIdle) return r;
        for (int k = 0; k < 8; k++) begin
            d = mActive[(k + mOffset) % 8];
            r[k*8 +: 8] = d[4] ? glyph(d[3:0]) : 8'hFF;
        end
`ifdef SEG_LZ_BLANK_EN
        if (mPhase == PhStatic) begin
            lead = 1'b1;
            for (int k = 7; k >= 1; k--) begin
                d = mActive[k];
                if (lead && d[4] && d[3:0] == 4'h0) r[k*8 +: 8] = 8'hFF;
                else lead = 1'b0;
            end
        end
`else
        lead = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [63:0] observedSegs();
        return {o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mShadow[i] = 5'd0;
            mActive[i] = 5'd0;
        end
        mOffset  = 0;
        mCount   = 0;
        mPending = 1'b0;
        mPhase   = PhIdle;
    endtask

    // One clock edge of the display rules, evaluated on the values present at that edge
    task automatic modelStep(input bit v, input int idx, input logic [4:0] data, input bit c, input bit m);
        logic [4:0] oldShadow [8];
        bit         wasPending;
        bit         doCopy;
        oldShadow  = mShadow;
        wasPending = mPending;
        doCopy     = 1'b0;
        if (mPhase == PhIdle) begin
            if (wasPending) begin
                doCopy = 1'b1;
                mPhase = m ? PhScroll : PhStatic;
            end
        end else if (mPhase == PhStatic) begin
            doCopy = wasPending;
            if (m) begin
                mPhase = PhScroll;
                mCount = 0;
            end
        end else begin
            if (!m) begin
                mPhase  = PhStatic;
                mOffset = 0;
                mCount  = 0;
            end else if (mCount == ClkNum - 1) begin
                mCount  = 0;
                mOffset = (mOffset + 1) % 8;
                doCopy  = wasPending;
            end else begin
                mCount = mCount + 1;
            end
        end
        if (doCopy) begin
            mActive  = oldShadow;
            mPending = 1'b0;
        end
        if (v && !wasPending) mShadow[idx] = data;
        if (c && !wasPending) mPending = 1'b1;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_segs"},  observedSegs(), expectedSegs());
        checkOutput({tag, "_ready"}, 64'(wrIf.wr_ready), 64'(!mPending));
        checkOutput({tag, "_busy"},  64'(busy), 64'(mPending));
    endtask

    task automatic applyStimulus(input bit v, input int idx, input logic [4:0] data,
                                 input bit c, input bit m, input string tag);
        wrIf.wr_valid = v;
        wrIf.wr_idx   = 3'(idx);
        wrIf.wr_data  = data;
        commit        = c;
        mode          = m;
        @(posedge clk);
        modelStep(v, idx, data, c, m);
        #1;
        compareAll(tag);
    endtask

    task automatic asyncReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_segs"},  observedSegs(), {8{8'hFF}});
        checkOutput({tag, "_rst_ready"}, 64'(wrIf.wr_ready), 64'd1);
        checkOutput({tag, "_rst_busy"},  64'(busy), 64'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        wrIf.wr_valid = 1'b0;
        wrIf.wr_idx   = 3'd0;
        wrIf.wr_data  = 5'd0;
        commit        = 1'b0;
        mode          = 1'b0;
        modelReset();
        #3;
        checkOutput("reset_segs",  observedSegs(), {8{8'hFF}});
        checkOutput("reset_ready", 64'(wrIf.wr_ready), 64'd1);
        checkOutput("reset_busy",  64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single digit, static display; nothing visible until the commit completes
        applyStimulus(1, 0, 5'h11, 0, 0, "t1_wr");
        applyStimulus(0, 0, 5'h00, 0, 0, "t1_wait");
        checkOutput("t1_precommit", observedSegs(), {8{8'hFF}});
        applyStimulus(0, 0, 5'h00, 1, 0, "t1_commit");
        checkOutput("t1_busy_high", 64'(busy), 64'd1);
        applyStimulus(0, 0, 5'h00, 0, 0, "t1_done");
        checkOutput("t1_seg0", 64'(o_seg0), 64'h9F);
        checkOutput("t1_seg71", {o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1}, {7{8'hFF}});
        checkOutput("t1_busy_low", 64'(busy), 64'd0);

        // Write and commit together, then a commit while busy is dropped
        applyStimulus(1, 3, 5'h1A, 1, 0, "t4_wrcommit");
        applyStimulus(0, 0, 5'h00, 1, 0, "t4_recommit");
        checkOutput("t4_seg3", 64'(o_seg3), 64'h11);
        applyStimulus(0, 0, 5'h00, 0, 0, "t4_after");
        checkOutput("t4_busy_once", 64'(busy), 64'd0);

        // Scrolling through digits 0..7
        asyncReset("t2");
        for (int k = 0; k < 8; k++) applyStimulus(1, k, 5'(5'h10 | k), 0, 0, "t2_wr");
        applyStimulus(0, 0, 5'h00, 1, 1, "t2_commit");
        applyStimulus(0, 0, 5'h00, 0, 1, "t2_enter");
        checkOutput("t2_start_seg0", 64'(o_seg0), 64'h03);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 5'h00, 0, 1, "t2_run");
        checkOutput("t2_step_seg0", 64'(o_seg0), 64'h9F);
        checkOutput("t2_step_seg7", 64'(o_seg7), 64'h03);
        for (int i = 0; i < 28; i++) applyStimulus(0, 0, 5'h00, 0, 1, "t2_run");
        checkOutput("t2_wrap_seg0", 64'(o_seg0), 64'h03);

        // Commit mid-step in scroll; writes during the pending window are refused
        for (int i = 0; i < 8 && mCount != 1; i++) applyStimulus(0, 0, 5'h00, 0, 1, "t3_align");
        applyStimulus(1, 6, 5'h1E, 1, 1, "t3_commit");
        for (int i = 0; i < 10 && mPending; i++) applyStimulus(1, 2, 5'h1F, 0, 1, "t3_blocked");
        checkOutput("t3_cleared", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 5'h00, 0, 1, "t3_show");

        // Reset while a scroll commit is pending
        applyStimulus(0, 0, 5'h00, 1, 1, "t5_commit");
        checkOutput("t5_pending", 64'(busy), 64'd1);
        asyncReset("t5");
        applyStimulus(0, 0, 5'h00, 0, 0, "t5_idle");

        // Leading zeros in static mode
        for (int k = 0; k < 8; k++) applyStimulus(1, k, (k == 4) ? 5'h11 : 5'h10, 0, 0, "t6_wr");
        applyStimulus(0, 0, 5'h00, 1, 0, "t6_commit");
        applyStimulus(0, 0, 5'h00, 0, 0, "t6_done");
        checkOutput("t6_seg4", 64'(o_seg4), 64'h9F);
        checkOutput("t6_seg30", {o_seg3, o_seg2, o_seg1, o_seg0}, {4{8'h03}});
`ifdef SEG_LZ_BLANK_EN
        checkOutput("t6_seg75", {o_seg7, o_seg6, o_seg5}, {3{8'hFF}});
`else
        checkOutput("t6_seg75", {o_seg7, o_seg6, o_seg5}, {3{8'h03}});
`endif

        // Random traffic with occasional mode flips and resets
        begin
            bit rMode;
            rMode = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 39) == 0) rMode = ~rMode;
                applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                              5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0, rMode, "rand");
                if ($urandom_range(0, 299) == 0) asyncReset("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
